rgb_fade_sequencer: RTL and testbench

Brightness sequencer that sits upstream of the RGB PWM controller. It converts a 6-bit switch colour setting (2 bits per channel) into three 5-bit duty levels (0..31). Each level ramps one LSB at a time toward its target, with updates aligned to PWM period boundaries, so the LED fades smoothly instead of stepping and never glitches mid-period.

---
 rtl/rgb_fade_sequencer.sv | 153 +++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_sequencer.sv
// Switch-driven RGB brightness sequencer: ramps three 5-bit duty levels one LSB per step on PWM frame boundaries.
// Optional perceptual gamma on the duty outputs: define RGB_FADE_GAMMA_EN.
module rgb_fade_sequencer #(
  parameter int PRESCALE     = 3125,
  parameter int STEP_PERIODS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] SW,
  input  logic       hold,
  output logic [4:0] duty_r,
  output logic [4:0] duty_g,
  output logic [4:0] duty_b,
  output logic       frame_start,
  output logic       busy
);

  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SCW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);
  localparam logic [SCW-1:0] ST_LAST = SCW'(STEP_PERIODS - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RAMP = 1'b1} state_t;

  function automatic logic [4:0] f_target(input logic [1:0] code);
    logic [4:0] t;
    case (code)
      2'b00:   t = 5'd0;
      2'b01:   t = 5'd10;
      2'b10:   t = 5'd21;
      2'b11:   t = 5'd31;
      default: t = 5'd0;
    endcase
    return t;
  endfunction

  function automatic logic [4:0] f_step(input logic [4:0] lvl, input logic [4:0] tgt);
    logic [4:0] n;
    if (lvl < tgt)      n = lvl + 5'd1;
    else if (lvl > tgt) n = lvl - 5'd1;
    else                n = lvl;
    return n;
  endfunction

  function automatic logic [4:0] f_duty(input logic [4:0] lvl);
`ifdef RGB_FADE_GAMMA_EN
    logic [9:0] sq;
    sq = {5'd0, lvl} * {5'd0, lvl};
    return 5'(sq >> 5);
`else
    return lvl;
`endif
  endfunction

  logic [4:0]     r_tgt_r, r_tgt_g, r_tgt_b;
  logic [4:0]     r_lvl_r, r_lvl_g, r_lvl_b;
  logic [4:0]     r_duty_r, r_duty_g, r_duty_b;
  logic [PW-1:0]  r_prescale;
  logic [4:0]     r_tick;
  logic [SCW-1:0] r_step_cnt;
  logic           r_frame_start;
  logic           r_busy;
  state_t         r_state;

  logic       w_frame_wrap, w_step_wrap, w_diff, w_do_step;
  logic [4:0] w_nxt_r, w_nxt_g, w_nxt_b;

  // Level updates land on the edge that raises frame_start, so the new duty is visible with the pulse.
  assign w_frame_wrap = (r_prescale == PS_LAST) && (r_tick == 5'd31);
  assign w_step_wrap  = w_frame_wrap && (r_step_cnt == ST_LAST);
  assign w_diff       = (r_lvl_r != r_tgt_r) || (r_lvl_g != r_tgt_g) || (r_lvl_b != r_tgt_b);
  assign w_do_step    = w_step_wrap && !hold && (r_state == S_RAMP);
  assign w_nxt_r      = w_do_step ? f_step(r_lvl_r, r_tgt_r) : r_lvl_r;
  assign w_nxt_g      = w_do_step ? f_step(r_lvl_g, r_tgt_g) : r_lvl_g;
  assign w_nxt_b      = w_do_step ? f_step(r_lvl_b, r_tgt_b) : r_lvl_b;

  // Target capture from the switches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tgt_r <= 5'd0;
      r_tgt_g <= 5'd0;
      r_tgt_b <= 5'd0;
    end else begin
      r_tgt_r <= f_target(SW[1:0]);
      r_tgt_g <= f_target(SW[3:2]);
      r_tgt_b <= f_target(SW[5:4]);
    end
  end

  // PWM period framing; keeps running through hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prescale    <= '0;
      r_tick        <= 5'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
      if (r_prescale == PS_LAST) begin
        r_prescale <= '0;
        r_tick     <= (r_tick == 5'd31) ? 5'd0 : r_tick + 5'd1;
      end else begin
        r_prescale <= r_prescale + PW'(1);
      end
    end
  end

  // Frames-per-step divider, frozen by hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_step_cnt <= '0;
    end else if (w_frame_wrap && !hold) begin
      r_step_cnt <= (r_step_cnt == ST_LAST) ? '0 : r_step_cnt + SCW'(1);
    end else begin
      r_step_cnt <= r_step_cnt;
    end
  end

  // Ramp FSM with level and duty registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_lvl_r  <= 5'd0;
      r_lvl_g  <= 5'd0;
      r_lvl_b  <= 5'd0;
      r_duty_r <= 5'd0;
      r_duty_g <= 5'd0;
      r_duty_b <= 5'd0;
    end else begin
      r_busy  <= w_diff;
      r_lvl_r <= w_nxt_r;
      r_lvl_g <= w_nxt_g;
      r_lvl_b <= w_nxt_b;
      if (w_frame_wrap) begin
        r_duty_r <= f_duty(w_nxt_r);
        r_duty_g <= f_duty(w_nxt_g);
        r_duty_b <= f_duty(w_nxt_b);
      end
      case (r_state)
        S_IDLE:  r_state <= w_diff ? S_RAMP : S_IDLE;
        S_RAMP:  r_state <= w_diff ? S_RAMP : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign duty_r      = r_duty_r;
  assign duty_g      = r_duty_g;
  assign duty_b      = r_duty_b;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer: expected duty triples are queued per frame when stimulus is applied.
module tb_rgb_fade_sequencer;

  localparam int PRESCALE     = 2;
  localparam int STEP_PERIODS = 1;
  localparam int FRAME        = 32 * PRESCALE;

  logic       clock, reset, hold;
  logic [5:0] SW;
  logic [4:0] duty_r, duty_g, duty_b;
  logic       frame_start, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] q_exp[$];
  logic [4:0]  m_r, m_g, m_b, t_r, t_g, t_b;

  rgb_fade_sequencer #(.PRESCALE(PRESCALE), .STEP_PERIODS(STEP_PERIODS)) dut (
    .clock(clock), .reset(reset), .SW(SW), .hold(hold),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .frame_start(frame_start), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] tgt_of(input logic [1:0] c);
    case (c)
      2'b00:   return 5'd0;
      2'b01:   return 5'd10;
      2'b10:   return 5'd21;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] exp_duty(input logic [4:0] l);
`ifdef RGB_FADE_GAMMA_EN
    int li;
    li = l;
    return 5'((li * li) / 32);
`else
    return l;
`endif
  endfunction

  function automatic logic [4:0] step_to(input logic [4:0] l, input logic [4:0] t);
    if (l < t) return l + 5'd1;
    if (l > t) return l - 5'd1;
    return l;
  endfunction

  task automatic set_sw(input logic [5:0] v);
    SW  = v;
    t_r = tgt_of(v[1:0]);
    t_g = tgt_of(v[3:2]);
    t_b = tgt_of(v[5:4]);
  endtask

  task automatic zero_model();
    m_r = 5'd0; m_g = 5'd0; m_b = 5'd0;
  endtask

  // Frames hs..he (1-based, relative to this call) are held: no step.
  task automatic model_push(input int n, input int hs, input int he);
    for (int f = 1; f <= n; f++) begin
      if (!(f >= hs && f <= he)) begin
        m_r = step_to(m_r, t_r);
        m_g = step_to(m_g, t_g);
        m_b = step_to(m_b, t_b);
      end
      q_exp.push_back({exp_duty(m_r), exp_duty(m_g), exp_duty(m_b)});
    end
  endtask

  task automatic wait_frame(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clock);
      cyc++;
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_frames(input string name, input int n, input int hs, input int he, input int first_cyc);
    bit          ok;
    int          cyc;
    logic [14:0] exp_v, got;
    for (int f = 1; f <= n; f++) begin
      wait_frame(ok, cyc);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL %s frame %0d: frame_start not seen within %0d cycles, required a pulse", name, f, 4 * FRAME);
        return;
      end
      if ((f > 1 || first_cyc > 0) && cyc !== ((f == 1) ? first_cyc : FRAME)) begin
        n_errors++;
        $display("FAIL %s frame %0d period: got %0d cycles, required %0d", name, f, cyc,
                 (f == 1) ? first_cyc : FRAME);
      end
      got = {duty_r, duty_g, duty_b};
      if (q_exp.size() == 0) begin
        n_errors++;
        $display("FAIL %s frame %0d: scoreboard empty, duty rgb=%0d/%0d/%0d", name, f, duty_r, duty_g, duty_b);
      end else begin
        exp_v = q_exp.pop_front();
        if (got !== exp_v) begin
          n_errors++;
          $display("FAIL %s frame %0d: duty rgb=%0d/%0d/%0d required %0d/%0d/%0d", name, f,
                   got[14:10], got[9:5], got[4:0], exp_v[14:10], exp_v[9:5], exp_v[4:0]);
        end
      end
      hold = ((f + 1) >= hs && (f + 1) <= he);
    end
    hold = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hold  = 1'b0;
    set_sw(6'b000000);
    zero_model();
    repeat (3) @(negedge clock);
    n_checks++;
    if ({duty_r, duty_g, duty_b, frame_start, busy} !== 17'd0) begin
      n_errors++;
      $display("FAIL reset_state: outputs=%h required 0", {duty_r, duty_g, duty_b, frame_start, busy});
    end
    reset = 1'b1;
    model_push(3, 0, -1);
    run_frames("reset_frame", 3, 0, -1, FRAME);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_up_ramp();
    set_sw(6'b000011);
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL up_busy_latency1: busy=%b required 0", busy);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL up_busy_latency2: busy=%b required 1", busy);
    end
    model_push(31, 0, -1);
    run_frames("up_ramp", 31, 0, -1, 0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL up_busy_final_step: busy=%b required 1", busy);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL up_busy_fall: busy=%b required 0", busy);
    end
  endtask

  task automatic test_down_ramp();
    set_sw(6'b000000);
    model_push(31, 0, -1);
    run_frames("down_ramp", 31, 0, -1, 0);
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL down_busy_fall: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reversal();
    set_sw(6'b110000);
    model_push(10, 0, -1);
    run_frames("reversal_up", 10, 0, -1, 0);
    set_sw(6'b000000);
    model_push(10, 0, -1);
    run_frames("reversal_down", 10, 0, -1, 0);
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reversal_busy_fall: busy=%b required 0", busy);
    end
  endtask

  task automatic test_mixed_hold();
    set_sw(6'b110110);
    model_push(36, 6, 10);
    run_frames("mixed_hold", 36, 6, 10, 0);
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mixed_busy_fall: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_ramp();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    zero_model();
    set_sw(6'b000011);
    model_push(17, 0, -1);
    run_frames("mid_ramp_pre", 17, 0, -1, FRAME);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if ({duty_r, duty_g, duty_b, frame_start, busy} !== 17'd0) begin
      n_errors++;
      $display("FAIL mid_ramp_async_reset: outputs=%h required 0", {duty_r, duty_g, duty_b, frame_start, busy});
    end
    @(negedge clock);
    reset = 1'b1;
    zero_model();
    model_push(3, 0, -1);
    run_frames("mid_ramp_restart", 3, 0, -1, FRAME);
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_reversal();
    test_mixed_hold();
    test_reset_mid_ramp();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
